// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux plus a one-hot grant; a tenure ends on request drop or MAX_HOLD expiry.
// Latency: grant/sel registered, 1 cycle from sampled request; one dead cycle between tenures.
// Backpressure: non-owner requests are held off until the next idle cycle; a timed-out owner yields to other pending requesters.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    state_t        state, state_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [1:0]    sel_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    grant_nxt;
    logic          timeout_nxt;
    logic [1:0]    win;
    logic          win_vld;
    logic          owner_req;
    logic          at_max;

    // Cyclic scan from ptr; descending loop so the nearest set bit wins.
    always_comb begin
        win     = ptr;
        win_vld = |req;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                win = ptr + 2'(i);
            end
        end
    end

    assign owner_req = req[sel];
    assign at_max    = (cnt == HOLD_MAX);

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        sel_nxt     = sel;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    grant_nxt = 4'b0001 << win;
                    sel_nxt   = win;
                    cnt_nxt   = CW'(1);
                    state_nxt = OWN;
                end
            end
            OWN: begin
                if (!owner_req || at_max) begin
                    // sel is left on the old owner so the mux never moves while granted
                    grant_nxt   = 4'b0000;
                    state_nxt   = IDLE;
                    ptr_nxt     = sel + 2'd1;
                    cnt_nxt     = '0;
                    timeout_nxt = owner_req && at_max;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant   <= 4'b0000;
            sel     <= 2'd0;
            ptr     <= 2'd0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            sel     <= sel_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            timeout <= timeout_nxt;
        end
    end

    assign busy = |grant;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (MAX_HOLD=2 and 4) with directed scenarios and a random phase.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req_a, req_b;
    logic [3:0] grant_a, grant_b;
    logic [1:0] sel_a, sel_b;
    logic       busy_a, busy_b, timeout_a, timeout_b;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(2), .CW(4)) u_a (
        .clk(clk), .reset_n(reset_n), .req(req_a),
        .grant(grant_a), .sel(sel_a), .busy(busy_a), .timeout(timeout_a)
    );

    mux4_rr_arbiter #(.MAX_HOLD(4), .CW(3)) u_b (
        .clk(clk), .reset_n(reset_n), .req(req_b),
        .grant(grant_b), .sel(sel_b), .busy(busy_b), .timeout(timeout_b)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       t;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_total = 0;
    int n_bad   = 0;

    int         m_mh [2] = '{2, 4};
    logic       m_own[2];
    logic [1:0] m_ptr[2];
    logic [1:0] m_sel[2];
    int         m_cnt[2];
    logic [3:0] m_g  [2];
    logic       m_to [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 1'b0;
            m_ptr[k] = 2'd0;
            m_sel[k] = 2'd0;
            m_cnt[k] = 0;
            m_g[k]   = 4'b0000;
            m_to[k]  = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] r, output exp_t e);
        bit found;
        found   = 1'b0;
        m_to[k] = 1'b0;
        if (!m_own[k]) begin
            for (int i = 0; i < 4; i++) begin
                int idx;
                idx = (int'(m_ptr[k]) + i) % 4;
                if (!found && r[idx]) begin
                    found    = 1'b1;
                    m_g[k]   = 4'b0001 << idx;
                    m_sel[k] = idx[1:0];
                    m_cnt[k] = 1;
                    m_own[k] = 1'b1;
                end
            end
        end else if (!r[m_sel[k]] || m_cnt[k] == m_mh[k]) begin
            m_to[k]  = r[m_sel[k]];
            m_g[k]   = 4'b0000;
            m_own[k] = 1'b0;
            m_ptr[k] = m_sel[k] + 2'd1;
            m_cnt[k] = 0;
        end else begin
            m_cnt[k]++;
        end
        e = '{g: m_g[k], s: m_sel[k], t: m_to[k]};
    endtask

    // Drive one cycle of requests, queue the expectation, then compare after the edge.
    task automatic cyc(input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        req_a = ra;
        req_b = rb;
        model_step(0, ra, e);
        q_a.push_back(e);
        model_step(1, rb, e);
        q_b.push_back(e);
        @(posedge clk);
        #1;
        e = q_a.pop_front();
        check("a_grant", grant_a, e.g);
        check("a_sel", sel_a, e.s);
        check("a_busy", busy_a, |e.g);
        check("a_timeout", timeout_a, e.t);
        check("a_onehot", $onehot0(grant_a), 1);
        e = q_b.pop_front();
        check("b_grant", grant_b, e.g);
        check("b_sel", sel_b, e.s);
        check("b_busy", busy_b, |e.g);
        check("b_timeout", timeout_b, e.t);
        check("b_onehot", $onehot0(grant_b), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant_a"}, grant_a, 0);
        check({tag, "_sel_a"}, sel_a, 0);
        check({tag, "_busy_a"}, busy_a, 0);
        check({tag, "_timeout_a"}, timeout_a, 0);
        check({tag, "_grant_b"}, grant_b, 0);
        check({tag, "_sel_b"}, sel_b, 0);
        check({tag, "_busy_b"}, busy_b, 0);
    endtask

    logic [3:0] t3_grant [15] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                  4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                  4'b0001, 4'b0001, 4'b0000};

    initial begin
        // 1: reset with all requests high
        reset_n = 1'b0;
        req_a   = 4'b1111;
        req_b   = 4'b1111;
        model_reset();
        #12;
        check_all_zero("t1_rst");
        @(negedge clk);
        reset_n = 1'b1;
        cyc(4'b1111, 4'b1111);
        check("t1_first_grant", grant_a, 4'b0001);
        check("t1_first_sel", sel_a, 0);
        cyc(4'b0000, 4'b0000);

        // 2: single requester on instance b
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0000, 4'b0100);
            check("t2_grant", grant_b, 4'b0100);
            check("t2_sel", sel_b, 2);
        end
        cyc(4'b0000, 4'b0000);
        check("t2_rel_grant", grant_b, 0);
        check("t2_rel_sel", sel_b, 2);
        check("t2_rel_timeout", timeout_b, 0);

        // 3: fairness with all requesting on MAX_HOLD=2 (move ptr to 0 first)
        cyc(4'b1000, 4'b0000);
        cyc(4'b0000, 4'b0000);
        for (int i = 0; i < 15; i++) begin
            cyc(4'b1111, 4'b0000);
            check("t3_grant", grant_a, t3_grant[i]);
            check("t3_timeout", timeout_a, (i % 3 == 2) ? 1 : 0);
        end

        // 4: pointer skip after a tenure by requester 1
        cyc(4'b0010, 4'b0000);
        cyc(4'b1001, 4'b0000);
        cyc(4'b1001, 4'b0000);
        check("t4_grant3", grant_a, 4'b1000);
        check("t4_sel3", sel_a, 3);
        cyc(4'b0001, 4'b0000);
        cyc(4'b0001, 4'b0000);
        check("t4_grant0", grant_a, 4'b0001);
        cyc(4'b0000, 4'b0000);

        // 5: timeout hands over to requester 3 on MAX_HOLD=4
        cyc(4'b0000, 4'b0010);
        check("t5_grant1", grant_b, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0000, 4'b1010);
            check("t5_hold", grant_b, 4'b0010);
            check("t5_no_to", timeout_b, 0);
        end
        cyc(4'b0000, 4'b1010);
        check("t5_rel", grant_b, 0);
        check("t5_timeout", timeout_b, 1);
        cyc(4'b0000, 4'b1010);
        check("t5_next", grant_b, 4'b1000);
        check("t5_to_clear", timeout_b, 0);
        cyc(4'b0000, 4'b0000);

        // 6: async reset mid-tenure
        for (int i = 0; i < 3; i++) cyc(4'b0000, 4'b0100);
        check("t6_pre", grant_b, 4'b0100);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(4'b1111, 4'b1111);
        check("t6_restart_a", grant_a, 4'b0001);
        check("t6_restart_b", grant_b, 4'b0001);

        // random phase
        for (int i = 0; i < 400; i++) begin
            cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux-selected datapath among four requesters.
- Drives the 2-bit select of the downstream 4:1 mux and a one-hot grant back to the requesters.
- Grants are locked until the owner drops its request or a hold-time limit expires. Every requester is guaranteed service within 3 tenures.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one owner may hold the grant. Legal range 1..255.
- CW, default 8: width of the internal hold counter. Must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector, bit i = requester i. A requester holds its bit high for as long as it wants the resource.
- grant  output  4  one-hot (or zero) grant vector, registered.
- sel  output  2  mux select, equal to the index of the current or last owner, registered.
- busy  output  1  high while any grant is asserted.
- timeout  output  1  one-cycle pulse on the cycle a tenure is ended by MAX_HOLD expiry.

Behaviour:
- Reset (reset_n=0, async, any time, including mid-tenure):
  - grant=0, sel=0, busy=0, timeout=0.
  - Priority pointer ptr=0, hold counter cnt=0, state=IDLE.
- States: IDLE, OWN.
- IDLE:
  - If req==0: stay in IDLE; grant=0, sel unchanged.
  - If req!=0: pick the winner w = first set bit scanning cyclically ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: grant=onehot(w), sel=w, busy=1, cnt=1, state=OWN.
  - Latency from req rising (sampled) to grant: 1 cycle.
- OWN (owner o = sel):
  - Release when req[o]==0 (sampled) or cnt==MAX_HOLD, whichever is first.
  - If no release condition holds: grant held, cnt increments; cnt saturates at MAX_HOLD.
  - On a release edge:
    - grant=0, busy=0, state=IDLE, ptr=(o+1) mod 4, cnt=0.
    - sel keeps o.
    - timeout=1 for this cycle only if the release was caused by cnt==MAX_HOLD and req[o] was still 1.
  - If both release conditions hold in the same cycle (req drop and cnt==MAX_HOLD), it counts as a normal release: timeout=0.
- Handover:
  - There is always exactly one dead cycle (grant=0) between consecutive tenures, so the mux select never changes while a grant is active.
  - sel changes only on the edge that asserts a new grant.
- Requests from non-owners are ignored during OWN; they are arbitrated in the following IDLE cycle.
- A timed-out owner that keeps requesting re-competes with ptr already advanced past it. It therefore yields to any other pending requester.
- Invariants:
  - grant is always zero or one-hot.
  - busy == |grant.
  - When grant!=0, grant[sel]==1.
- With MAX_HOLD=1, every tenure lasts exactly 1 cycle. timeout pulses whenever the owner is still requesting at the release edge.
- req bits may toggle on any cycle; only sampled values at the rising edge matter.

Test Plan:
1. Reset with req=4'b1111 held:
   - Required: grant=0, sel=0, busy=0 during reset.
   - First edge after release: grant=4'b0001, sel=0.
2. Single requester req=4'b0100 for 3 cycles, then 0:
   - grant=4'b0100, sel=2 for 3 cycles.
   - Then grant=0, sel stays 2, timeout never asserts.
3. Round-robin fairness, req=4'b1111 held, MAX_HOLD=2:
   - Required grant sequence (each for 2 cycles, separated by a dead cycle): 0001, 0010, 0100, 1000, 0001.
   - timeout pulses at each release.
4. Pointer skip, req=4'b1001 after a tenure by requester 1 (ptr=2):
   - Next grant=4'b1000 (sel=3), then 4'b0001.
5. Timeout priority, MAX_HOLD=4, requester 1 holds req with req[3] also high:
   - grant=0010 for 4 cycles.
   - timeout=1 on the release cycle.
   - Next grant=1000, not 0010.
6. Async reset asserted mid-tenure (grant=0100, cnt=3):
   - grant, busy and sel go to 0 immediately without a clock edge.
   - After deassertion, arbitration restarts from ptr=0.
